// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole sequencer.
// Game FSM / mole sub-state encodings, LFSR taps and small helpers.
package mole_game_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      DONE  = 2'd2,
      CLEAR = 2'd3
   } game_state_e;

   typedef enum logic {
      MOLE_GAP = 1'b0,
      MOLE_UP  = 1'b1
   } mole_state_e;

   localparam int MS_PER_S = 1000;

   // x^16 + x^14 + x^13 + x^11 + 1, shift-left Fibonacci form (bits 15,13,12,10)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLK_HZ/1000 enabled cycles.
// Synchronous clear restarts the count so the first tick lands a full period later.
module ms_tick_gen #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic clkIn,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int DIV = CLK_HZ / 1000;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clkIn) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole top sequencer: game FSM, seconds countdown, mole scheduler,
// button edge detection and the mole-select LFSR. All outputs are registered.
module mole_game_ctrl
   import mole_game_pkg::*;
#(
   parameter int          CLK_HZ       = 100_000_000,
   parameter int          N_MOLES      = 4,
   parameter int          GAME_SECONDS = 30,
   parameter int          MOLE_UP_MS   = 800,
   parameter int          GAP_MS       = 200,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic               clkIn,
   input  logic               reset,
   input  logic               start_btn,
   input  logic [N_MOLES-1:0] hit_btn,
   output logic               game_active,
   output logic               timer_expired,
   output logic               player_scored,
   output logic [N_MOLES-1:0] mole_onehot,
   output logic [5:0]         seconds_left
);

   localparam int MSW  = $clog2(max3(MOLE_UP_MS, GAP_MS, MS_PER_S) + 1);
   localparam int IDXW = $clog2(N_MOLES);

   localparam logic [MSW-1:0]     GAP_LAST  = MSW'(GAP_MS - 1);
   localparam logic [MSW-1:0]     UP_LAST   = MSW'(MOLE_UP_MS - 1);
   localparam logic [MSW-1:0]     SEC_LAST  = MSW'(MS_PER_S - 1);
   localparam logic [5:0]         SECS_INIT = 6'(GAME_SECONDS);
   localparam logic [N_MOLES-1:0] MOLE_ONE  = N_MOLES'(1);

   game_state_e        state_q,    state_d;
   mole_state_e        mole_st_q,  mole_st_d;
   logic [5:0]         seconds_q,  seconds_d;
   logic [MSW-1:0]     ms_cnt_q,   ms_cnt_d;
   logic [MSW-1:0]     sec_ms_q,   sec_ms_d;
   logic [N_MOLES-1:0] mole_q,     mole_d;
   logic [IDXW-1:0]    prev_idx_q, prev_idx_d;
   logic               scored_q,   scored_d;
   logic               active_q,   active_d;
   logic               expired_q,  expired_d;
   logic [15:0]        lfsr_q;
   logic               start_prev_q;
   logic [N_MOLES-1:0] hit_prev_q;

   logic               start_rise;
   logic [N_MOLES-1:0] hit_rise;
   logic               hit_on_mole;
   logic               ms_tick;
   logic               play_en;
   logic               game_go;
   logic               last_second;
   logic [IDXW-1:0]    raw_idx, pick_idx;

   assign start_rise = start_btn & ~start_prev_q;

   for (genvar gi = 0; gi < N_MOLES; gi++) begin : g_hit_edge
      assign hit_rise[gi] = hit_btn[gi] & ~hit_prev_q[gi];
   end

   assign hit_on_mole = |(hit_rise & mole_q);
   assign play_en     = (state_q == PLAY);
   assign game_go     = ((state_q == IDLE) && start_rise) || (state_q == CLEAR);
   assign last_second = ms_tick && (sec_ms_q == SEC_LAST) && (seconds_q == 6'd1);

   // Never light the same mole twice in a row.
   assign raw_idx  = lfsr_q[IDXW-1:0];
   assign pick_idx = (raw_idx == prev_idx_q) ? raw_idx + IDXW'(1) : raw_idx;

   ms_tick_gen #(
      .CLK_HZ(CLK_HZ)
   ) u_ms_tick (
      .clkIn (clkIn),
      .reset (reset),
      .enable(play_en),
      .clear (game_go),
      .tick  (ms_tick)
   );

   always_comb begin
      state_d    = state_q;
      mole_st_d  = mole_st_q;
      seconds_d  = seconds_q;
      ms_cnt_d   = ms_cnt_q;
      sec_ms_d   = sec_ms_q;
      mole_d     = mole_q;
      prev_idx_d = prev_idx_q;
      scored_d   = 1'b0;

      unique case (state_q)
         IDLE:  if (start_rise) state_d = PLAY;
         CLEAR: state_d = PLAY;
         DONE:  if (start_rise) state_d = CLEAR;
         PLAY: begin
            if (ms_tick) begin
               if (sec_ms_q == SEC_LAST) begin
                  sec_ms_d = '0;
                  if (seconds_q != 6'd0) seconds_d = seconds_q - 6'd1;
               end else begin
                  sec_ms_d = sec_ms_q + MSW'(1);
               end
            end

            // Priority: game expiry beats a hit, a hit beats the UP timeout.
            if (last_second) begin
               state_d   = DONE;
               mole_d    = '0;
               mole_st_d = MOLE_GAP;
               ms_cnt_d  = '0;
            end else if ((mole_st_q == MOLE_UP) && hit_on_mole) begin
               scored_d  = 1'b1;
               mole_d    = '0;
               mole_st_d = MOLE_GAP;
               ms_cnt_d  = '0;
            end else if (ms_tick) begin
               if (mole_st_q == MOLE_GAP) begin
                  if (ms_cnt_q == GAP_LAST) begin
                     mole_d     = MOLE_ONE << pick_idx;
                     prev_idx_d = pick_idx;
                     mole_st_d  = MOLE_UP;
                     ms_cnt_d   = '0;
                  end else begin
                     ms_cnt_d = ms_cnt_q + MSW'(1);
                  end
               end else begin
                  if (ms_cnt_q == UP_LAST) begin
                     mole_d    = '0;
                     mole_st_d = MOLE_GAP;
                     ms_cnt_d  = '0;
                  end else begin
                     ms_cnt_d = ms_cnt_q + MSW'(1);
                  end
               end
            end
         end
      endcase

      if (game_go) begin
         seconds_d = SECS_INIT;
         sec_ms_d  = '0;
         ms_cnt_d  = '0;
         mole_st_d = MOLE_GAP;
         mole_d    = '0;
      end

      active_d  = (state_d == PLAY) || (state_d == DONE);
      expired_d = (state_d == DONE);
   end

   always_ff @(posedge clkIn) begin
      if (!reset) begin
         state_q    <= IDLE;
         mole_st_q  <= MOLE_GAP;
         seconds_q  <= SECS_INIT;
         ms_cnt_q   <= '0;
         sec_ms_q   <= '0;
         mole_q     <= '0;
         prev_idx_q <= '0;
         scored_q   <= 1'b0;
         active_q   <= 1'b0;
         expired_q  <= 1'b0;
         lfsr_q     <= LFSR_SEED;
      end else begin
         state_q    <= state_d;
         mole_st_q  <= mole_st_d;
         seconds_q  <= seconds_d;
         ms_cnt_q   <= ms_cnt_d;
         sec_ms_q   <= sec_ms_d;
         mole_q     <= mole_d;
         prev_idx_q <= prev_idx_d;
         scored_q   <= scored_d;
         active_q   <= active_d;
         expired_q  <= expired_d;
         lfsr_q     <= lfsr_step(lfsr_q);
      end
   end

   // Track the buttons even in reset so a level held through reset is not an edge.
   always_ff @(posedge clkIn) begin
      start_prev_q <= start_btn;
      hit_prev_q   <= hit_btn;
   end

   assign game_active   = active_q;
   assign timer_expired = expired_q;
   assign player_scored = scored_q;
   assign mole_onehot   = mole_q;
   assign seconds_left  = seconds_q;

endmodule
